// File: rtl/fetch_decode_buffer_pkg.sv
// Shared pipeline types for the fetch/decode boundary: the canonical NOP and the
// queued fetch entry layout.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pre_pc;
  } fd_entry_t;
endpackage

// File: rtl/fetch_decode_buffer.sv
// In-order instruction queue between fetch and decode, flushed on redirect.
// Optional macro FDBUF_STATS_EN adds stall_cycles and flush_count counters.
module fetch_decode_buffer
  import pipeline_pkg::*;
#(
  parameter int DataWidth = XLEN,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DataWidth-1:0]       instruction_in,
  input  logic [DataWidth-1:0]       pc_in,
  input  logic [DataWidth-1:0]       pre_pc_in,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DataWidth-1:0]       instruction_out,
  output logic [DataWidth-1:0]       pc_out,
  output logic [DataWidth-1:0]       pre_pc_out,
`ifdef FDBUF_STATS_EN
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_count,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a transfer happens on a rising edge when valid and ready are both
  // high and flush is low; ready never depends combinationally on the other side.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  fd_entry_t     storage [DEPTH];
  fd_entry_t     head;
  logic          push;
  logic          pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data slots carry no reset; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= '{instr: instruction_in, pc: pc_in, pre_pc: pre_pc_in};
    end
  end

  assign head = storage[rd_ptr];

  always_comb begin
    instruction_out = NOP_INSTR;
    pc_out          = '0;
    pre_pc_out      = '0;
    if (out_valid) begin
      instruction_out = head.instr;
      pc_out          = head.pc;
      pre_pc_out      = head.pre_pc;
    end
  end

`ifdef FDBUF_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cycles <= stall_cycles + 32'd1;
      if (flush)                 flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_fetch_decode_buffer;
  import pipeline_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] instruction_in;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] pre_pc_in;
  logic          in_ready;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] instruction_out;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] pre_pc_out;
  logic [CW-1:0] count;
`ifdef FDBUF_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;
  int unsigned   exp_stall;
  int unsigned   exp_flush;
`endif

  int vectors     = 0;
  int miscompares = 0;

  fd_entry_t     exp_q[$];
  logic [DW-1:0] popped_q[$];

  fetch_decode_buffer #(.DataWidth(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .pre_pc_in       (pre_pc_in),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pre_pc_out      (pre_pc_out),
`ifdef FDBUF_STATS_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .count           (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every head output against the reference queue
  task automatic check_outputs();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_ppc;
    e_instr = NOP_INSTR;
    e_pc    = 32'd0;
    e_ppc   = 32'd0;
    if (exp_q.size() != 0) begin
      e_instr = exp_q[0].instr;
      e_pc    = exp_q[0].pc;
      e_ppc   = exp_q[0].pre_pc;
    end
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk("instruction_out", instruction_out, e_instr);
    chk("pc_out", pc_out, e_pc);
    chk("pre_pc_out", pre_pc_out, e_ppc);
`ifdef FDBUF_STATS_EN
    chk("stall_cycles", stall_cycles, exp_stall);
    chk("flush_count", flush_count, exp_flush);
`endif
  endtask

  // driver: apply one cycle of inputs at negedge, advance model at posedge, check at next negedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] ppc, input logic fl, input logic ordy);
    bit full;
    bit do_push;
    bit do_pop;
    in_valid       = v;
    instruction_in = ins;
    pc_in          = pcv;
    pre_pc_in      = ppc;
    flush          = fl;
    out_ready      = ordy;
    full    = (exp_q.size() == DEPTH);
    do_push = v && !full && !fl;
    do_pop  = (exp_q.size() != 0) && ordy && !fl;
    if (do_pop && out_valid) popped_q.push_back(instruction_out);
    @(posedge clk);
`ifdef FDBUF_STATS_EN
    if (v && full) exp_stall++;
    if (fl) exp_flush++;
`endif
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{instr: ins, pc: pcv, pre_pc: ppc});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
`ifdef FDBUF_STATS_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] words [6];
    int          idx;
    words[0] = 32'h0000_000A;
    words[1] = 32'h0000_000B;
    words[2] = 32'h0000_000C;
    words[3] = 32'h0000_000D;
    words[4] = 32'h0000_000E;
    words[5] = 32'h0000_000F;
    rst = 1'b1; in_valid = 1'b0; instruction_in = '0; pc_in = '0; pre_pc_in = '0;
    flush = 1'b0; out_ready = 1'b0;
`ifdef FDBUF_STATS_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // single pass-through
    cycle(1'b1, 32'h0050_0093, 32'h4, 32'h0, 1'b0, 1'b1);
    chk("pass_instr", instruction_out, 32'h0050_0093);
    chk("pass_pc", pc_out, 32'h4);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("pass_drain", 32'(count), 32'd0);

    // fill to capacity with decode stalled; third word must bounce
    cycle(1'b1, words[0], 32'h100, 32'h0FC, 1'b0, 1'b0);
    cycle(1'b1, words[1], 32'h104, 32'h100, 1'b0, 1'b0);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, words[2], 32'h108, 32'h104, 1'b0, 1'b0);
    chk("fill_head", instruction_out, words[0]);

    // concurrent push/pop from full across the pointer wrap; fetch retries until accepted
    popped_q.delete();
    idx = 2;
    for (int i = 0; i < 4; i++) begin
      bit acc;
      acc = (exp_q.size() < DEPTH);
      cycle(1'b1, words[idx], 32'h100 + 32'(4 * idx), 32'h0FC + 32'(4 * idx), 1'b0, 1'b1);
      if (acc) idx++;
    end
    chk("order_n", 32'(popped_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] got;
      got = (i < popped_q.size()) ? popped_q[i] : 32'hFFFF_FFFF;
      chk("order", got, words[i]);
    end

    // asynchronous reset while holding two entries
    cycle(1'b1, words[5], 32'h200, 32'h1FC, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instruction_out, 32'h0000_0013);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    exp_q.delete();
`ifdef FDBUF_STATS_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    rst = 1'b0;

    // flush with a full queue and a word on the input
    cycle(1'b1, 32'h1111_0001, 32'h300, 32'h2FC, 1'b0, 1'b0);
    cycle(1'b1, 32'h1111_0002, 32'h304, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 32'h308, 32'h304, 1'b1, 1'b1);
    chk("flush_count0", 32'(count), 32'd0);
    chk("flush_valid0", 32'(out_valid), 32'd0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("flush_word_gone", 32'(out_valid), 32'd0);

`ifdef FDBUF_STATS_EN
    reset_pulse();
    cycle(1'b1, 32'h2222_0001, 32'h400, 32'h3FC, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_0002, 32'h404, 32'h400, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h2222_0003, 32'h408, 32'h404, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stats_stall", stall_cycles, 32'd5);
    chk("stats_flush", flush_count, 32'd2);
`endif

    // random traffic
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
